// File: rtl/xnor_pkg.sv
// Shared definitions for the XNOR stream checker: FSM state encoding and default sizes.
package xnor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/xnor_vec_reg.sv
// Registered bitwise XNOR with load enable plus an all-ones reduce; 1-cycle latency.
// Outputs hold their value when load is low; no backpressure of its own.
module xnor_vec_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic             match
);

    logic [WIDTH-1:0] w_xnor;

    assign w_xnor = ~(a ^ b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f     <= '0;
            match <= 1'b0;
        end else if (load) begin
            f     <= w_xnor;
            match <= &w_xnor;
        end
    end

endmodule

// File: rtl/xnor_stream_checker.sv
// Burst compare stage: XNORs len word pairs, tracks mismatch count and first error index.
// Result 1 cycle after accept; in_ready is high for the whole RUN state, independent of inputs.
module xnor_stream_checker
    import xnor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic             f_valid,
    output logic             match,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             err_seen
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] r_mismatch_cnt;
    logic [CNT_W-1:0] r_first_err_idx;
    logic             r_err_seen;
    logic             r_f_valid;

    logic             w_run;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_last;
    logic             w_mis;

    assign w_run      = (r_state == ST_RUN);
    assign w_accept   = in_valid && w_run;
    assign w_start_ok = start && (r_state == ST_IDLE);
    assign w_last     = (r_beat_cnt == (r_len - CNT_W'(1)));
    assign w_mis      = (a != b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Statistics are cleared only by an honoured start, so they stay readable after the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len           <= '0;
            r_beat_cnt      <= '0;
            r_mismatch_cnt  <= '0;
            r_first_err_idx <= '0;
            r_err_seen      <= 1'b0;
            r_f_valid       <= 1'b0;
        end else begin
            r_f_valid <= w_accept;
            if (w_start_ok) begin
                r_len           <= len;
                r_beat_cnt      <= '0;
                r_mismatch_cnt  <= '0;
                r_first_err_idx <= '0;
                r_err_seen      <= 1'b0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                if (w_mis) begin
                    if (r_mismatch_cnt != {CNT_W{1'b1}}) begin
                        r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                    end
                    if (!r_err_seen) begin
                        r_first_err_idx <= r_beat_cnt;
                        r_err_seen      <= 1'b1;
                    end
                end
            end
        end
    end

    xnor_vec_reg #(
        .WIDTH (WIDTH)
    ) u_vec (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .a     (a),
        .b     (b),
        .f     (f),
        .match (match)
    );

    assign in_ready      = w_run;
    assign busy          = w_run;
    assign done          = (r_state == ST_DONE);
    assign f_valid       = r_f_valid;
    assign mismatch_cnt  = r_mismatch_cnt;
    assign first_err_idx = r_first_err_idx;
    assign err_seen      = r_err_seen;

endmodule
